// File: rtl/svd_pkg.sv
// ---------------------------------------------------------------------------
// svd_pkg : shared widths, word indices and state type for the SVD stream ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package svd_pkg;

  localparam int A_W   = 10;
  localparam int S_W   = 14;
  localparam int UV_W  = 8;
  localparam int WORDS = 12;

  localparam logic [3:0] IDX_S0   = 4'd0;
  localparam logic [3:0] IDX_U0   = 4'd4;
  localparam logic [3:0] IDX_V0   = 4'd8;
  localparam logic [3:0] IDX_LAST = 4'd11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/svd_stream_ctrl.sv
// ---------------------------------------------------------------------------
// svd_stream_ctrl : collects A0..A3, runs the 2x2 CORDIC SVD core, streams S/U/V
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module svd_stream_ctrl
  import svd_pkg::*;
#(
  parameter int TIMEOUT = 63,
  parameter int OUT_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_W-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic              core_start,
  input  logic              core_ready,
  output logic [A_W-1:0]    core_A0,
  output logic [A_W-1:0]    core_A1,
  output logic [A_W-1:0]    core_A2,
  output logic [A_W-1:0]    core_A3,
  input  logic [S_W-1:0]    core_S0,
  input  logic [S_W-1:0]    core_S1,
  input  logic [S_W-1:0]    core_S2,
  input  logic [S_W-1:0]    core_S3,
  input  logic [UV_W-1:0]   core_U0,
  input  logic [UV_W-1:0]   core_U1,
  input  logic [UV_W-1:0]   core_U2,
  input  logic [UV_W-1:0]   core_U3,
  input  logic [UV_W-1:0]   core_V0,
  input  logic [UV_W-1:0]   core_V1,
  input  logic [UV_W-1:0]   core_V2,
  input  logic [UV_W-1:0]   core_V3
);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [3:0]        r_idx;
  logic [7:0]        r_wdog;
  logic [A_W-1:0]    r_a   [4];
  logic [OUT_W-1:0]  r_buf [WORDS];
  logic              r_err;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_out_last;
  logic              r_busy;
  logic              r_core_start;

  logic [OUT_W-1:0]  w_cap [WORDS];
  logic [7:0]        w_wdog_nxt;
  logic [3:0]        w_idx_nxt;

  // Words are sign-extended only; downstream knows the per-index fraction width.
  always_comb begin
    w_cap[IDX_S0]         = OUT_W'($signed(core_S0));
    w_cap[IDX_S0 + 4'd1]  = OUT_W'($signed(core_S1));
    w_cap[IDX_S0 + 4'd2]  = OUT_W'($signed(core_S2));
    w_cap[IDX_S0 + 4'd3]  = OUT_W'($signed(core_S3));
    w_cap[IDX_U0]         = OUT_W'($signed(core_U0));
    w_cap[IDX_U0 + 4'd1]  = OUT_W'($signed(core_U1));
    w_cap[IDX_U0 + 4'd2]  = OUT_W'($signed(core_U2));
    w_cap[IDX_U0 + 4'd3]  = OUT_W'($signed(core_U3));
    w_cap[IDX_V0]         = OUT_W'($signed(core_V0));
    w_cap[IDX_V0 + 4'd1]  = OUT_W'($signed(core_V1));
    w_cap[IDX_V0 + 4'd2]  = OUT_W'($signed(core_V2));
    w_cap[IDX_V0 + 4'd3]  = OUT_W'($signed(core_V3));
  end

  assign w_wdog_nxt = r_wdog + 8'd1;
  assign w_idx_nxt  = r_idx + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_COLLECT;
      r_cnt        <= 2'd0;
      r_idx        <= 4'd0;
      r_wdog       <= 8'd0;
      r_err        <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_core_start <= 1'b0;
      for (int i = 0; i < 4; i++) r_a[i] <= '0;
      for (int i = 0; i < WORDS; i++) r_buf[i] <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (in_valid && r_in_ready) begin
            r_a[r_cnt] <= in_data;
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state      <= ST_START;
              r_core_start <= 1'b1;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b1;
            end
          end
        end

        // Core ready is still high from the previous run here, so it is not looked at.
        ST_START: begin
          r_state <= ST_BUSY;
          r_wdog  <= 8'd0;
        end

        ST_BUSY: begin
          if (core_ready) begin
            for (int i = 0; i < WORDS; i++) r_buf[i] <= w_cap[i];
            r_idx       <= IDX_S0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_cap[IDX_S0];
            r_out_last  <= 1'b0;
            r_state     <= ST_DRAIN;
          end else begin
            r_wdog <= w_wdog_nxt;
            if (w_wdog_nxt == 8'(TIMEOUT)) begin
              r_err      <= 1'b1;
              r_state    <= ST_COLLECT;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          if (out_ready) begin
            if (r_idx == IDX_LAST) begin
              r_idx       <= 4'd0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= '0;
              r_state     <= ST_COLLECT;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_data <= r_buf[w_idx_nxt];
              r_out_last <= (w_idx_nxt == IDX_LAST);
            end
          end
        end

        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  assign err        = r_err;
  assign core_start = r_core_start;
  assign core_A0    = r_a[0];
  assign core_A1    = r_a[1];
  assign core_A2    = r_a[2];
  assign core_A3    = r_a[3];

endmodule

`default_nettype wire

// File: tb/tb_svd_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_svd_stream_ctrl : directed + randomized bench with a behavioural core stub
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_svd_stream_ctrl;

  localparam int TO = 5;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          err;
  logic          core_start;
  logic          core_ready;
  logic [9:0]    core_A0, core_A1, core_A2, core_A3;
  logic [13:0]   core_S0, core_S1, core_S2, core_S3;
  logic [7:0]    core_U0, core_U1, core_U2, core_U3;
  logic [7:0]    core_V0, core_V1, core_V2, core_V3;

  int n_pass  = 0;
  int n_total = 0;

  int res_s[4];
  int res_u[4];
  int res_v[4];
  int stub_cnt;
  bit stub_hang = 1'b0;

  svd_stream_ctrl #(.TIMEOUT(TO), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err),
    .core_start(core_start), .core_ready(core_ready),
    .core_A0(core_A0), .core_A1(core_A1), .core_A2(core_A2), .core_A3(core_A3),
    .core_S0(core_S0), .core_S1(core_S1), .core_S2(core_S2), .core_S3(core_S3),
    .core_U0(core_U0), .core_U1(core_U1), .core_U2(core_U2), .core_U3(core_U3),
    .core_V0(core_V0), .core_V1(core_V1), .core_V2(core_V2), .core_V3(core_V3)
  );

  always #5 clk = ~clk;

  // Core stub: drops ready on start, raises it 1..3 cycles later with the preset results.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_ready <= 1'b1;
      stub_cnt   <= 0;
      {core_S0, core_S1, core_S2, core_S3} <= '0;
      {core_U0, core_U1, core_U2, core_U3} <= '0;
      {core_V0, core_V1, core_V2, core_V3} <= '0;
    end else if (core_start) begin
      core_ready <= 1'b0;
      stub_cnt   <= stub_hang ? 0 : int'($urandom_range(1, 3));
      core_S0 <= 14'(res_s[0]); core_S1 <= 14'(res_s[1]);
      core_S2 <= 14'(res_s[2]); core_S3 <= 14'(res_s[3]);
      core_U0 <= 8'(res_u[0]);  core_U1 <= 8'(res_u[1]);
      core_U2 <= 8'(res_u[2]);  core_U3 <= 8'(res_u[3]);
      core_V0 <= 8'(res_v[0]);  core_V1 <= 8'(res_v[1]);
      core_V2 <= 8'(res_v[2]);  core_V3 <= 8'(res_v[3]);
    end else if (!core_ready && stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) core_ready <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rand_results();
    for (int i = 0; i < 4; i++) begin
      res_s[i] = int'($urandom_range(0, 16383)) - 8192;
      res_u[i] = int'($urandom_range(0, 255)) - 128;
      res_v[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after the start pulse.
  task automatic send_set(input int a0, input int a1, input int a2, input int a3, input bit gaps);
    int vals[4];
    int g;
    vals = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      g = !gaps ? 0 : (i == 1) ? 2 : (i == 3) ? 1 : 0;
      repeat (g) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      check("in_ready_collect", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 10'(vals[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("core_start_pulse", {31'd0, core_start}, 32'd1);
    check("in_ready_low",     {31'd0, in_ready},   32'd0);
    check("busy_high",        {31'd0, busy},       32'd1);
    check("core_A0", {22'd0, core_A0}, {22'd0, 10'(a0)});
    check("core_A1", {22'd0, core_A1}, {22'd0, 10'(a1)});
    check("core_A2", {22'd0, core_A2}, {22'd0, 10'(a2)});
    check("core_A3", {22'd0, core_A3}, {22'd0, 10'(a3)});
    @(negedge clk);
    check("core_start_single", {31'd0, core_start}, 32'd0);
  endtask

  // mode 0: out_ready high, 1: toggling, 2: random. Stops after stop_after handshakes.
  task automatic drain(input int mode, input int stop_after);
    logic [OW-1:0] exp_w[12];
    int  k = 0;
    int  budget = 0;
    bit  tog = 1'b1;
    bit  saw_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_w[i]     = OW'(res_s[i]);
      exp_w[4 + i] = OW'(res_u[i]);
      exp_w[8 + i] = OW'(res_v[i]);
    end
    while (k < stop_after && budget < 300) begin
      if (core_start) saw_start = 1'b1;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      if (out_valid) begin
        check("out_data",      {16'd0, out_data},       {16'd0, exp_w[k]});
        check("out_last",      {31'd0, out_last},       {31'd0, k == 11});
        check("in_ready_drain", {31'd0, in_ready},      32'd0);
        if (out_ready) k++;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0;
    check("handshake_count", k, stop_after);
    check("no_start_in_drain", {31'd0, saw_start}, 32'd0);
    if (stop_after == 12) begin
      check("out_valid_done", {31'd0, out_valid}, 32'd0);
      check("in_ready_done",  {31'd0, in_ready},  32'd1);
      check("busy_done",      {31'd0, busy},      32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_out_data",   {16'd0, out_data},   32'd0);
    check("rst_err",        {31'd0, err},        32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_A0",         {22'd0, core_A0},    32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Identity
    res_s = '{32, 0, 0, 32}; res_u = '{64, 0, 0, 64}; res_v = '{64, 0, 0, 64};
    send_set(4, 0, 0, 4, 1'b0);
    drain(0, 12);

    // Backpressure
    send_set(4, 0, 0, 4, 1'b0);
    drain(1, 12);

    // Input gaps
    rand_results();
    send_set(5, -3, 100, -200, 1'b1);
    drain(0, 12);

    // Watchdog: 5 BUSY cycles without core ready
    stub_hang = 1'b1;
    send_set(1, 2, 3, 4, 1'b0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      check("wd_no_valid", {31'd0, out_valid}, 32'd0);
      if (c == 5) check("wd_err_early", {31'd0, err}, 32'd0);
    end
    check("wd_err",      {31'd0, err},      32'd1);
    check("wd_in_ready", {31'd0, in_ready}, 32'd1);
    check("wd_busy",     {31'd0, busy},     32'd0);
    stub_hang = 1'b0;

    // Reset mid-drain, then a fresh full set
    rand_results();
    send_set(7, 8, 9, 10, 1'b0);
    drain(0, 3);
    check("err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b0;
    #1;
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_out_data",  {16'd0, out_data},  32'd0);
    check("mr_out_last",  {31'd0, out_last},  32'd0);
    check("mr_in_ready",  {31'd0, in_ready},  32'd1);
    check("mr_busy",      {31'd0, busy},      32'd0);
    check("mr_err",       {31'd0, err},       32'd0);
    check("mr_A3",        {22'd0, core_A3},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rand_results();
    send_set(-1, 2, -3, 4, 1'b0);
    drain(0, 12);

    // Back-to-back with negative elements and near-zero off-diagonal S
    rand_results();
    res_s[1] = int'($urandom_range(0, 4)) - 2;
    res_s[2] = int'($urandom_range(0, 4)) - 2;
    send_set(-8, 12, 3, -20, 1'b0);
    drain(0, 12);
    rand_results();
    send_set(-8, 12, 3, -20, 1'b0);
    drain(2, 12);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      rand_results();
      send_set(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      drain(2, 12);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
